// File: rtl/mul_ctrl.sv
// Control wrapper around an external 2-register Booth multiplier: tracks the ops in flight,
// applies backpressure, and supports flush. Optional perf counters with MUL_CTRL_PERF_CNT_EN.
module mul_ctrl #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,

    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    output logic             mul_stall,
    output logic             mul_rst_n,
    input  logic [31:0]      mul_m,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,

    output logic             busy,
    output logic [1:0]       state
`ifdef MUL_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_hold
`endif
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic [TAG_W-1:0] t1_q, t1_d;
    logic [TAG_W-1:0] t2_q, t2_d;
    logic [1:0]       state_q, state_d;

    logic hold;
    logic accept;

    assign hold      = v2_q & ~out_ready;
    assign in_ready  = ~hold & ~flush;
    assign accept    = in_valid & in_ready;
    assign mul_stall = hold;
    assign mul_rst_n = ~rst;

    assign mul_a = accept ? op_a : 32'd0;
    assign mul_b = accept ? op_b : 32'd0;

    // Valid/tag pipeline mirrors the two multiplier stage registers.
    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        t1_d = t1_q;
        t2_d = t2_q;
        if (!hold) begin
            t1_d = in_tag;
            t2_d = t1_q;
        end
        if (flush) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
        end else if (!hold) begin
            v1_d = accept;
            v2_d = v1_q;
        end
    end

    always_comb begin
        state_d = StRun;
        if (flush || !(v1_d || v2_d)) begin
            state_d = StIdle;
        end else if (v2_d && !out_ready) begin
            state_d = StHold;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            t1_q    <= '0;
            t2_q    <= '0;
            state_q <= StIdle;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            state_q <= state_d;
        end
    end

    assign out_valid  = v2_q;
    assign out_result = mul_m;
    assign out_tag    = t2_q;
    assign busy       = v1_q | v2_q;
    assign state      = state_q;

`ifdef MUL_CTRL_PERF_CNT_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_hold_q, perf_hold_d;

    always_comb begin
        perf_ops_d  = perf_ops_q + {31'd0, accept};
        perf_hold_d = perf_hold_q + {31'd0, hold};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops_q  <= 32'd0;
            perf_hold_q <= 32'd0;
        end else begin
            perf_ops_q  <= perf_ops_d;
            perf_hold_q <= perf_hold_d;
        end
    end

    assign perf_ops  = perf_ops_q;
    assign perf_hold = perf_hold_q;
`endif

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a behavioural 2-stage multiplier model on the mul_* side.
module tb_mul_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  in_tag;
    logic        flush;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_stall;
    logic        mul_rst_n;
    logic [31:0] mul_m;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;
    logic [1:0]  state;
`ifdef MUL_CTRL_PERF_CNT_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_hold;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mul_ctrl #(.TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .in_tag     (in_tag),
        .flush      (flush),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_stall  (mul_stall),
        .mul_rst_n  (mul_rst_n),
        .mul_m      (mul_m),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy),
        .state      (state)
`ifdef MUL_CTRL_PERF_CNT_EN
        ,
        .perf_ops   (perf_ops),
        .perf_hold  (perf_hold)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-register multiplier with hold and sync active-low reset.
    logic [31:0] p1_q, p2_q;
    always_ff @(posedge clk) begin
        if (!mul_rst_n) begin
            p1_q <= 32'd0;
            p2_q <= 32'd0;
        end else if (!mul_stall) begin
            p1_q <= mul_a * mul_b;
            p2_q <= p1_q;
        end
    end
    assign mul_m = p2_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t);
        in_valid = v;
        op_a     = a;
        op_b     = b;
        in_tag   = t;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    logic [31:0] b2b_a [3];
    logic [31:0] b2b_b [3];
    logic [31:0] b2b_r [3];
    int          seen;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        in_tag    = 5'd0;
        flush     = 1'b0;
        out_ready = 1'b1;
        step();
        step();

        // Reset values
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_tag",   32'(out_tag),   32'd0);
        check_eq("rst_busy",      32'(busy),      32'd0);
        check_eq("rst_mul_stall", 32'(mul_stall), 32'd0);
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("rst_mul_rst_n", 32'(mul_rst_n), 32'd0);
        check_eq("rst_state",     32'(state),     32'd0);
        rst = 1'b0;
        step();

        // Single op: result exactly two cycles after accept
        drive(1'b1, 32'd7, 32'd6, 5'd3);
        check_eq("single_in_ready", 32'(in_ready), 32'd1);
        check_eq("single_mul_a", mul_a, 32'd7);
        step();
        drive(1'b0, 32'd0, 32'd0, 5'd0);
        check_eq("single_n1_valid", 32'(out_valid), 32'd0);
        check_eq("single_n1_busy",  32'(busy),      32'd1);
        check_eq("single_n1_mul_a", mul_a,          32'd0);
        step();
        check_eq("single_n2_valid",  32'(out_valid), 32'd1);
        check_eq("single_n2_result", out_result,     32'd42);
        check_eq("single_n2_tag",    32'(out_tag),   32'd3);
        step();
        check_eq("single_n3_valid", 32'(out_valid), 32'd0);
        check_eq("single_n3_busy",  32'(busy),      32'd0);
        check_eq("single_n3_state", 32'(state),     32'd0);

        // Back-to-back with wrap-around products
        b2b_a[0] = 32'hFFFF_FFFF; b2b_b[0] = 32'd2;       b2b_r[0] = 32'hFFFF_FFFE;
        b2b_a[1] = 32'h0001_0000; b2b_b[1] = 32'h1_0000;  b2b_r[1] = 32'd0;
        b2b_a[2] = 32'd12345;     b2b_b[2] = 32'd678;     b2b_r[2] = 32'd8369910;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, b2b_a[i], b2b_b[i], 5'(i + 10));
            else       drive(1'b0, 32'd0, 32'd0, 5'd0);
            if (i >= 2) begin
                check_eq($sformatf("b2b_valid%0d", i - 2),  32'(out_valid), 32'd1);
                check_eq($sformatf("b2b_result%0d", i - 2), out_result,     b2b_r[i - 2]);
                check_eq($sformatf("b2b_tag%0d", i - 2),    32'(out_tag),   32'(i + 8));
            end
            if (i == 2) check_eq("b2b_state_run", 32'(state), 32'd1);
            step();
        end
        check_eq("b2b_drained", 32'(out_valid), 32'd0);

        // Backpressure: two in flight, three cycles of out_ready=0
        out_ready = 1'b0;
        drive(1'b1, 32'd5, 32'd5, 5'd1);
        step();
        drive(1'b1, 32'd3, 32'd4, 5'd2);
        step();
        drive(1'b1, 32'd9, 32'd9, 5'd7);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("bp_in_ready%0d", i), 32'(in_ready),  32'd0);
            check_eq($sformatf("bp_stall%0d", i),    32'(mul_stall), 32'd1);
            check_eq($sformatf("bp_state%0d", i),    32'(state),     32'd2);
            check_eq($sformatf("bp_valid%0d", i),    32'(out_valid), 32'd1);
            check_eq($sformatf("bp_result%0d", i),   out_result,     32'd25);
            check_eq($sformatf("bp_tag%0d", i),      32'(out_tag),   32'd1);
            step();
        end
        drive(1'b0, 32'd0, 32'd0, 5'd0);
        out_ready = 1'b1;
        #1;
        check_eq("bp_rel_result0", out_result,   32'd25);
        check_eq("bp_rel_tag0",    32'(out_tag), 32'd1);
        step();
        check_eq("bp_rel_valid1",  32'(out_valid), 32'd1);
        check_eq("bp_rel_result1", out_result,     32'd12);
        check_eq("bp_rel_tag1",    32'(out_tag),   32'd2);
        step();
        check_eq("bp_rel_done", 32'(out_valid), 32'd0);

        // Flush with two in flight and a concurrent request
        out_ready = 1'b0;
        drive(1'b1, 32'd11, 32'd11, 5'd4);
        step();
        drive(1'b1, 32'd13, 32'd13, 5'd5);
        step();
        flush = 1'b1;
        drive(1'b1, 32'd17, 32'd17, 5'd6);
        check_eq("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 5'd0);
        check_eq("flush_valid", 32'(out_valid), 32'd0);
        check_eq("flush_busy",  32'(busy),      32'd0);
        check_eq("flush_state", 32'(state),     32'd0);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (out_valid) seen++;
            step();
        end
        check_eq("flush_no_result", 32'(seen), 32'd0);

        // Asynchronous reset between edges with ops in flight
        out_ready = 1'b0;
        drive(1'b1, 32'd2, 32'd3, 5'd8);
        step();
        drive(1'b1, 32'd4, 32'd5, 5'd9);
        step();
        drive(1'b0, 32'd0, 32'd0, 5'd0);
        check_eq("arst_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_busy",  32'(busy),      32'd0);
        check_eq("arst_state", 32'(state),     32'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (out_valid) seen++;
            step();
        end
        check_eq("arst_no_stale", 32'(seen), 32'd0);

`ifdef MUL_CTRL_PERF_CNT_EN
        // Perf counters: three accepts, two hold cycles
        do_reset();
        check_eq("perf_rst_ops", perf_ops, 32'd0);
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 32'd1, 5'd1);
        step();
        drive(1'b1, 32'd2, 32'd2, 5'd2);
        step();
        drive(1'b0, 32'd0, 32'd0, 5'd0);
        step();
        step();
        out_ready = 1'b1;
        drive(1'b1, 32'd3, 32'd3, 5'd3);
        step();
        drive(1'b0, 32'd0, 32'd0, 5'd0);
        step();
        step();
        step();
        check_eq("perf_ops",  perf_ops,  32'd3);
        check_eq("perf_hold", perf_hold, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
